if_stage: RTL

- Instruction-fetch stage of the single-clock core.
- Owns the PC register and drives the word index into the distributed-RAM instruction memory, which returns read data combinationally in the same cycle.
- Registers {pc, inst} into an IF/ID pipeline register presented to the decode stage with a valid/ready handshake.
- Accepts a taken-branch redirect from execute; detects misaligned fetch addresses (ADEF).

---
 rtl/if_stage_if.sv | 14 +
 rtl/if_stage.sv | 105 ++++++++++
 2 files changed

// File: rtl/if_stage_if.sv
// IF -> ID pipeline-register handshake bundle.
// The fetch stage drives valid and the payload. The decode stage drives ready.
interface if_stage_if;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_adef;

    modport master (output id_valid, output id_pc, output id_inst, output id_adef,
                    input  id_ready);
    modport slave  (input  id_valid, input  id_pc, input  id_inst, input  id_adef,
                    output id_ready);
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage.
// The stage owns the PC and indexes a combinational-read instruction memory.
// It latches {pc, inst} into the IF/ID register, which uses a valid/ready handshake.
// It takes taken-branch redirects from execute.
// A misaligned PC produces an ADEF entry and halts fetch until the next redirect.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000,
    parameter int          ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic [31:0]       inst_rdata,
    input  logic              br_taken,
    input  logic [31:0]       br_target,
    if_stage_if.master        id,
    output logic [31:0]       fetch_cnt
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    state_t      r_state,    w_state_nx;
    logic [31:0] r_pc,       w_pc_nx;
    logic [31:0] r_id_pc,    w_id_pc_nx;
    logic [31:0] r_id_inst,  w_id_inst_nx;
    logic [31:0] r_cnt,      w_cnt_nx;
    logic        r_id_valid, w_id_valid_nx;
    logic        r_id_adef,  w_id_adef_nx;
    logic        w_acc;
    logic        w_hs;

    // The IF/ID register can take a new entry when it is empty or is drained this cycle.
    assign w_acc = !r_id_valid || id.id_ready;
    assign w_hs  = r_id_valid && id.id_ready;

    // State, PC and IF/ID register update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_id_valid <= 1'b0;
            r_id_pc    <= 32'h0;
            r_id_inst  <= 32'h0;
            r_id_adef  <= 1'b0;
            r_cnt      <= 32'h0;
        end else begin
            r_state    <= w_state_nx;
            r_pc       <= w_pc_nx;
            r_id_valid <= w_id_valid_nx;
            r_id_pc    <= w_id_pc_nx;
            r_id_inst  <= w_id_inst_nx;
            r_id_adef  <= w_id_adef_nx;
            r_cnt      <= w_cnt_nx;
        end
    end

    // Next-state logic. Priority order: redirect, then fetch, then drain, then stall.
    always_comb begin
        w_state_nx    = r_state;
        w_pc_nx       = r_pc;
        w_id_valid_nx = r_id_valid;
        w_id_pc_nx    = r_id_pc;
        w_id_inst_nx  = r_id_inst;
        w_id_adef_nx  = r_id_adef;
        w_cnt_nx      = r_cnt;

        // A redirect flushes the held entry, so a coincident handshake is not counted.
        if (w_hs && !br_taken)
            w_cnt_nx = r_cnt + 32'd1;

        if (br_taken) begin
            w_pc_nx       = br_target;
            w_id_valid_nx = 1'b0;
            w_state_nx    = fetch_en ? S_RUN : S_IDLE;
        end else begin
            if (r_state == S_RUN && fetch_en && w_acc) begin
                w_id_pc_nx    = r_pc;
                w_id_valid_nx = 1'b1;
                if (r_pc[1:0] == 2'b00) begin
                    w_id_inst_nx = inst_rdata;
                    w_id_adef_nx = 1'b0;
                    w_pc_nx      = r_pc + 32'd4;
                end else begin
                    // The PC is left unchanged. Only a redirect can move it out of HALT.
                    w_id_inst_nx = 32'h0;
                    w_id_adef_nx = 1'b1;
                    w_state_nx   = S_HALT;
                end
            end else if (w_acc) begin
                w_id_valid_nx = 1'b0;
                if (r_state == S_RUN)
                    w_state_nx = S_IDLE;
            end
            if (r_state == S_IDLE && fetch_en)
                w_state_nx = S_RUN;
        end
    end

    assign inst_addr   = r_pc[ADDR_W+1:2];
    assign id.id_valid = r_id_valid;
    assign id.id_pc    = r_id_pc;
    assign id.id_inst  = r_id_inst;
    assign id.id_adef  = r_id_adef;
    assign fetch_cnt   = r_cnt;
endmodule
